// File: rtl/regfile_pkg.sv
// Shared defaults and types for the register file.
package regfile_pkg;

    localparam int REGFILE_DATA_W = 64;
    localparam int REGFILE_ADDR_W = 5;
    localparam int REGFILE_DEPTH  = 32;

    // Ascending vectors: index 0 is the MSB.
    typedef logic [0:REGFILE_DATA_W-1] data_t;
    typedef logic [0:REGFILE_ADDR_W-1] addr_t;

endpackage

// File: rtl/register_file.sv
// Register file with two combinational read ports and one synchronous write port.
// Every register, address 0 included, is writable.
// An asynchronous active-low reset clears the whole array immediately.
module register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W = REGFILE_DATA_W,
    parameter int ADDR_W = REGFILE_ADDR_W,
    parameter int DEPTH  = REGFILE_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [0:ADDR_W-1] Ad_a,
    input  logic [0:ADDR_W-1] Ad_b,
    input  logic [0:ADDR_W-1] Ad_c,
    input  logic [0:DATA_W-1] data_wr,
    input  logic              wr_acc,
    output logic [0:DATA_W-1] data_a,
    output logic [0:DATA_W-1] data_b
);

    logic [0:DATA_W-1] regs_q [0:DEPTH-1];

    // Array update: async clear, otherwise write only on a definite wr_acc of 1.
    // A write arriving on the same edge that releases reset still sees
    // rst_n low, so it is dropped; the first accepted write is the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_acc === 1'b1) begin
            regs_q[Ad_c] <= data_wr;
        end
    end

    // Read muxes are purely combinational, with no write-to-read bypass.
    // A same-address write shows up only after the edge.
    assign data_a = regs_q[Ad_a];
    assign data_b = regs_q[Ad_b];

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file.
// It uses directed vector tables, hand-written reset and write sequences,
// and random traffic checked against an array model.
module tb_register_file;

    logic        clk;
    logic        rst_n;
    logic [0:4]  ad_a;
    logic [0:4]  ad_b;
    logic [0:4]  ad_c;
    logic [0:63] data_wr;
    logic        wr_acc;
    logic [0:63] data_a;
    logic [0:63] data_b;

    int checks;
    int errors;

    // Reference contents: register n holds model[n].
    logic [63:0] model [32];

    typedef struct {
        string       name;
        logic        wr;
        logic [4:0]  c;
        logic [63:0] wd;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [63:0] exp_a;
        logic [63:0] exp_b;
    } vec_t;

    vec_t vecs [6];

    register_file dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .Ad_a    (ad_a),
        .Ad_b    (ad_b),
        .Ad_c    (ad_c),
        .data_wr (data_wr),
        .wr_acc  (wr_acc),
        .data_a  (data_a),
        .data_b  (data_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Checks both read ports for one address pair against the model.
    task automatic check_reads(input string tag, input logic [4:0] a, input logic [4:0] b);
        ad_a = a;
        ad_b = b;
        #1;
        check({tag, "_a"}, data_a, model[a]);
        check({tag, "_b"}, data_b, model[b]);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 64'd0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        wr_acc  = 1'b0;
        ad_a    = '0;
        ad_b    = '0;
        ad_c    = '0;
        data_wr = '0;
        clear_model();

        // Reset: every address reads zero on both ports.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            check_reads($sformatf("reset_%0d", i), 5'(i), 5'(31 - i));
        end
        $display("reset released, all addresses read zero");

        // Directed vectors: inputs applied before an edge, outputs read after it.
        vecs[0] = '{"write_r1",     1'b1, 5'd1, 64'd1,                  5'd1, 5'd0, 64'd1,          64'd0};
        vecs[1] = '{"hold_r1",      1'b0, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 5'd1, 64'd1,          64'd1};
        vecs[2] = '{"write_r0",     1'b1, 5'd0, 64'd1,                  5'd0, 5'd0, 64'd1,          64'd1};
        vecs[3] = '{"hold_r0",      1'b0, 5'd0, 64'd5,                  5'd0, 5'd1, 64'd1,          64'd1};
        vecs[4] = '{"write_r7",     1'b1, 5'd7, 64'hDEAD_BEEF_0123_4567, 5'd7, 5'd0, 64'hDEAD_BEEF_0123_4567, 64'd1};
        vecs[5] = '{"overwrite_r1", 1'b1, 5'd1, 64'h8000_0000_0000_0001, 5'd7, 5'd1, 64'hDEAD_BEEF_0123_4567, 64'h8000_0000_0000_0001};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            wr_acc  = vecs[i].wr;
            ad_c    = vecs[i].c;
            data_wr = vecs[i].wd;
            ad_a    = vecs[i].a;
            ad_b    = vecs[i].b;
            @(posedge clk);
            #1;
            if (vecs[i].wr) model[vecs[i].c] = vecs[i].wd;
            check({vecs[i].name, "_a"}, data_a, vecs[i].exp_a);
            check({vecs[i].name, "_b"}, data_b, vecs[i].exp_b);
            $display("vec %s wr=%0d c=%0d a=%h b=%h", vecs[i].name, vecs[i].wr, vecs[i].c, data_a, data_b);
        end

        // Read during write to 31: old value before the edge, new value after it.
        @(negedge clk);
        ad_a    = 5'd31;
        ad_c    = 5'd31;
        data_wr = 64'hA5A5_A5A5_A5A5_A5A5;
        wr_acc  = 1'b1;
        #1;
        check("rdw_before", data_a, 64'd0);
        @(posedge clk);
        #1;
        model[31] = 64'hA5A5_A5A5_A5A5_A5A5;
        check("rdw_after", data_a, 64'hA5A5_A5A5_A5A5_A5A5);
        $display("read-during-write addr 31 -> %h", data_a);

        // Zero-latency read: the address changes mid-cycle and the data follows.
        @(negedge clk);
        wr_acc = 1'b0;
        check_reads("addr_change", 5'd7, 5'd31);
        check_reads("addr_same", 5'd31, 5'd31);

        // Data glitches between edges do not write; X on wr_acc does not write.
        @(negedge clk);
        wr_acc  = 1'b1;
        ad_c    = 5'd2;
        data_wr = 64'h1111;
        #2;
        wr_acc  = 1'b0;
        @(posedge clk);
        #1;
        check_reads("glitch_r2", 5'd2, 5'd2);
        @(negedge clk);
        wr_acc  = 1'bx;
        data_wr = 64'h2222;
        @(posedge clk);
        #1;
        check_reads("x_wr_acc_r2", 5'd2, 5'd1);
        wr_acc = 1'b0;

        // Random traffic checked against the array model.
        for (int n = 0; n < 200; n++) begin
            logic        w;
            logic [4:0]  c;
            logic [63:0] d;
            @(negedge clk);
            w = 1'($urandom_range(0, 1));
            c = 5'($urandom_range(0, 31));
            d = {$urandom, $urandom};
            wr_acc  = w;
            ad_c    = c;
            data_wr = d;
            check_reads("rand_pre", 5'($urandom_range(0, 31)), c);
            @(posedge clk);
            if (w) model[c] = d;
            #1;
            check("rand_post_b", data_b, model[c]);
            if (n % 50 == 0) $display("random #%0d wr=%0d c=%0d d=%h", n, w, c, d);
        end

        // Fill every register with a nonzero value, then reset between edges.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            wr_acc  = 1'b1;
            ad_c    = 5'(i);
            data_wr = 64'(i + 1) * 64'h0101_0101_0101_0101;
            @(posedge clk);
            model[i] = 64'(i + 1) * 64'h0101_0101_0101_0101;
        end
        @(negedge clk);
        wr_acc = 1'b0;
        check_reads("filled", 5'd0, 5'd31);
        #1;
        rst_n = 1'b0;
        clear_model();
        for (int i = 0; i < 32; i++) begin
            check_reads($sformatf("async_rst_%0d", i), 5'(i), 5'(i));
        end
        $display("async reset mid-cycle cleared all addresses");

        // Writes while reset is held are ignored.
        wr_acc  = 1'b1;
        ad_c    = 5'd3;
        data_wr = 64'd77;
        @(posedge clk);
        #1;
        check_reads("write_in_reset", 5'd3, 5'd3);

        // Release coincident with an edge: that write is dropped, the next is taken.
        @(negedge clk);
        ad_c    = 5'd4;
        data_wr = 64'd99;
        @(posedge clk);
        // Nonblocking so that the edge still sees reset asserted.
        rst_n <= 1'b1;
        #1;
        check_reads("coincident_release", 5'd4, 5'd4);
        @(posedge clk);
        #1;
        model[4] = 64'd99;
        check_reads("first_write_after_release", 5'd4, 5'd3);
        wr_acc = 1'b0;
        $display("post-reset write addr 4 -> %h", data_a);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_W, default 64, SHALL set the register and data-port width in bits.
REQ-002 Parameter ADDR_W, default 5, SHALL set the address width in bits.
REQ-003 Parameter DEPTH, default 32 (2**ADDR_W), SHALL set the number of registers.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 Port rst_n, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-006 Port Ad_a, input, ADDR_W bits, SHALL be the read address for port A.
REQ-007 Port Ad_b, input, ADDR_W bits, SHALL be the read address for port B.
REQ-008 Port Ad_c, input, ADDR_W bits, SHALL be the write address.
REQ-009 Port data_wr, input, DATA_W bits, SHALL be the write data.
REQ-010 Port wr_acc, input, 1 bit, SHALL be the write enable (1 = write).
REQ-011 Port data_a, output, DATA_W bits, SHALL be the read data for port A.
REQ-012 Port data_b, output, DATA_W bits, SHALL be the read data for port B.
REQ-013 All vectors SHALL be declared ascending ([0:N-1]); index 0 is the MSB.

Function
REQ-014 Storage SHALL be DEPTH registers of DATA_W bits each, all writable, including address 0.
REQ-015 On a rising clk edge with wr_acc=1 and rst_n=1, register[Ad_c] SHALL take the value of data_wr.
REQ-016 With wr_acc=0, no register SHALL change.
REQ-017 data_a SHALL equal register[Ad_a] combinationally, with zero-cycle latency from an address change.
REQ-018 data_b SHALL equal register[Ad_b] combinationally, with zero-cycle latency from an address change.
REQ-019 Both read ports SHALL be independent; Ad_a = Ad_b SHALL return identical data on both ports.
REQ-020 Read during write to the same address: the outputs SHALL show the old value until the edge and the new value immediately after it; there is no write-to-read bypass.
REQ-021 wr_acc, Ad_c and data_wr SHALL be sampled only at the rising edge; glitches between edges SHALL have no effect.
REQ-022 Any X on wr_acc SHALL NOT be treated as a write; implementations SHALL gate the write with wr_acc === 1.

Reset
REQ-023 Asserting rst_n=0 SHALL immediately, without waiting for a clock edge, clear every register to 0, so that data_a = data_b = 0.
REQ-024 While rst_n=0, writes SHALL be ignored.
REQ-025 A write coincident with rst_n deasserting SHALL be ignored; the first write is accepted on the next rising edge.
REQ-026 Reset mid-operation SHALL discard all stored contents.

Structure
REQ-027 A shared package regfile_pkg SHALL hold the DATA_W, ADDR_W and DEPTH defaults and the data/address typedefs.
REQ-028 The block SHALL be flat, with one always block for the array and continuous assigns for the two read muxes.
REQ-029 The block SHALL contain no sub-module; the clock generator belongs to the bench only.

Verification
REQ-030 Reset -> rst_n=0 then 1, any Ad_a/Ad_b -> data_a = data_b = 0.
REQ-031 Write then read -> Ad_c=1, data_wr=1, wr_acc=1, one edge; then wr_acc=0, Ad_a=1 -> data_a=1, and Ad_b=0 -> data_b=0.
REQ-032 Hold -> wr_acc=0, Ad_c=1, data_wr=64'hFFFF_FFFF_FFFF_FFFF, one edge -> register 1 still reads 1.
REQ-033 Address 0 -> Ad_c=0, data_wr=1, wr_acc=1, one edge; Ad_a=Ad_b=0 -> data_a = data_b = 1, and the value is unchanged after a later edge with wr_acc=0.
REQ-034 Read during write -> Ad_a=Ad_c=31, data_wr=64'hA5A5_A5A5_A5A5_A5A5, wr_acc=1 -> data_a = 0 before the edge and 64'hA5A5_A5A5_A5A5_A5A5 after it.
REQ-035 Asynchronous reset mid-run -> all 32 registers written with nonzero values, rst_n pulsed low between edges -> outputs are 0 at once for every address.
